// File: rtl/tmu2_dpram_be.sv
// TMU2 texel/line buffer RAM: 1R/1W dual-port with byte enables, read-through or
// read-old collision handling, optional output register and a zeroing clear sweep.
module tmu2_dpram_be #(
    parameter int depth  = 11,
    parameter int width  = 32,
    parameter bit outreg = 1'b0,
    parameter bit bypass = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [depth-1:0]     ra,
    input  logic                 re,
    output logic [width-1:0]     rd,
    input  logic [depth-1:0]     wa,
    input  logic                 we,
    input  logic [width/8-1:0]   wbe,
    input  logic [width-1:0]     wd,
    input  logic                 clear,
    output logic                 busy
);
    localparam int nbytes = width / 8;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t           state, state_nxt;
    logic [depth-1:0] cnt, cnt_nxt;

    // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                cnt_nxt = cnt + depth'(1);
                if (cnt == '1)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_CLEAR);

    // Single write port shared by the sweep and the user; clear acceptance beats a same-cycle write.
    logic              mem_we;
    logic [depth-1:0]  mem_wa;
    logic [width-1:0]  mem_wd;
    logic [nbytes-1:0] mem_be;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        mem_be = wbe;
        if (!sys_rst_n) begin
            mem_we = 1'b0;
        end else if (busy) begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = '0;
            mem_be = '1;
        end else begin
            mem_we = we && !clear;
        end
    end

    logic [width-1:0] mem [2**depth];

    // NOTE: the array itself is never reset; zeroing is the sweep's job, which keeps it a plain block RAM.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int i = 0; i < nbytes; i++) begin
                if (mem_be[i])
                    mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    logic [depth-1:0]  rar, rar_nxt;
    logic              rd_zero;
    logic [width-1:0]  ram_q;
    logic [nbytes-1:0] fwd_be;
    logic [width-1:0]  fwd_d;
    logic [width-1:0]  rd_pre;

    assign rar_nxt = !sys_rst_n ? '0 : (re ? ra : rar);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rar     <= '0;
            rd_zero <= 1'b1;
        end else if (re) begin
            rar     <= ra;
            rd_zero <= busy;
        end
    end

    if (bypass) begin : g_read_through
        // Re-read the held address every cycle and patch in lanes written at the same edge.
        always_ff @(posedge sys_clk) begin
            ram_q <= mem[rar_nxt];
            fwd_d <= mem_wd;
            if (!sys_rst_n)
                fwd_be <= '0;
            else if (mem_we && (mem_wa == rar_nxt))
                fwd_be <= mem_be;
            else
                fwd_be <= '0;
        end
    end else begin : g_read_old
        always_ff @(posedge sys_clk) begin
            if (sys_rst_n && re)
                ram_q <= mem[ra];
        end
        assign fwd_be = '0;
        assign fwd_d  = '0;
    end

    always_comb begin
        rd_pre = ram_q;
        for (int i = 0; i < nbytes; i++) begin
            if (fwd_be[i])
                rd_pre[8*i +: 8] = fwd_d[8*i +: 8];
        end
        if (rd_zero)
            rd_pre = '0;
    end

    if (outreg) begin : g_outreg
        logic             re_q;
        logic [width-1:0] out_q;

        // Read-through keeps tracking the held word; read-old only refreshes after a capture.
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                re_q  <= 1'b0;
                out_q <= '0;
            end else begin
                re_q <= re;
                if (bypass || re_q)
                    out_q <= rd_pre;
            end
        end
        assign rd = out_q;
    end else begin : g_direct
        assign rd = rd_pre;
    end

endmodule

// File: doc/tmu2_dpram_be.md
Name: tmu2_dpram_be

Overview:
Parametrised 1-read/1-write dual-port RAM, the next generation of the TMU2 texel/line buffer RAM. It adds per-byte write enables, a selectable collision mode (read-through or read-old), an optional output register for timing, and a built-in clear sequencer that zeroes the whole array after reset or on request. It sits between TMU2 pipeline stages as a scratch/cache store; a `busy` output stalls producers while the array is being cleared.

Parameters:
- depth, 11: log2 of capacity in words; array holds 2^depth words.
- width, 32: word width in bits; must be a multiple of 8.
- outreg, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- bypass, 1: 1 is read-through (new data on collision and on later writes to the held address); 0 is read-old (data snapshot at capture).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- ra  in  depth  read address.
- re  in  1  read enable; captures ra.
- rd  out  width  read data.
- wa  in  depth  write address.
- we  in  1  write enable.
- wbe  in  width/8  byte enables; bit i covers wd[8i+7:8i].
- wd  in  width  write data.
- clear  in  1  single-cycle request to zero the array.
- busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (sys_rst_n=0 at an edge):
  - rar, output register and rd go to 0; busy goes to 1.
  - Clear counter goes to 0; FSM enters CLEAR.
  - Reset asserted mid-clear restarts the sweep at address 0.
  - RAM contents are changed only by the sweep, never by reset itself.
- FSM states:
  - IDLE: busy=0. clear=1 at an edge moves to CLEAR with counter=0.
  - CLEAR: busy=1. Each cycle writes all-zero to ram[counter] and increments the counter. When counter=2^depth-1, that write occurs and the next state is IDLE. The sweep takes exactly 2^depth cycles.
  - clear while in CLEAR is ignored; the sweep does not restart.
- Writes:
  - In IDLE, we=1 writes byte i of wd into ram[wa] for each wbe[i]=1; other bytes keep their old values.
  - wbe=0 with we=1 is a no-op.
  - we is dropped while busy=1, and in the cycle where IDLE accepts clear (clear wins).
- Reads, outreg=0:
  - re=1 at an edge loads rar<=ra; rd shows ram[rar] after that edge.
  - re=0 holds rar.
- Reads, outreg=1:
  - The output register loads the outreg=0 value on the edge after a re=1 edge, so data appears 2 edges after ra is presented.
  - Otherwise the output register holds.
- bypass=1:
  - rd always equals the current contents of ram[rar], including a write to ra with the same byte lanes at the capture edge.
  - Any later write to rar is visible one edge after that write (outreg=0) or two edges after it (outreg=1).
  - The implementation uses synchronous-read RAM plus an explicit merge/forward path, so it must infer block RAM.
- bypass=0:
  - rd is the word as it was before the capture edge; later writes to rar are not reflected until the next re.
- Reads during busy:
  - Reads are accepted, but rd returns 0 for any read whose capture edge occurred with busy=1.
  - A per-stage flag tracks this through the output register.
- Address wrap: addresses are depth bits wide; the counter wraps only via the CLEAR→IDLE exit.
- Width rules: no arithmetic on data; the counter is depth+0 bits, and termination is detected by the all-ones compare.

Test Plan:
1. Power-up: hold sys_rst_n=0 for 2 cycles, then release → busy=1 for exactly 2^depth cycles (2048). Afterwards, reading every address returns 0x00000000.
2. Byte enables: write 0xAABBCCDD to wa=5 with wbe=1111, then 0x11223344 with wbe=0101. A read of ra=5 returns 0xAA22CC44 after 1 cycle (outreg=0) or 2 cycles (outreg=1).
3. Collision: ram[7]=0x1, then same-cycle we (wa=7, wd=0x2, wbe=1111) and re (ra=7). bypass=1 gives rd=0x2; bypass=0 gives rd=0x1. With re held low, a further write of 0x3 to 7 gives rd=0x3 (bypass=1) or rd stays 0x1 (bypass=0).
4. Clear request: fill addresses 0..15 with nonzero data, pulse clear together with we to wa=3. The write is dropped, busy=1 for 2048 cycles, and afterwards all reads return 0. we during busy leaves no trace.
5. Reset mid-clear: pulse clear, then assert sys_rst_n=0 at sweep count 100 → the sweep restarts at 0 and busy stays high a full 2048 cycles after release. A second clear pulse during busy does not extend it.
6. Reads during busy: re with ra=9 (ram[9] nonzero before clear) issued on the first busy cycle → rd=0. A re issued after busy falls returns 0.
